vga_scan_controller: RTL
========================

// Module: vga_scan_controller
// PURPOSE
// Master 640x480@60 scan sequencer. Divides the system clock into a pixel tick and runs horizontal/vertical counters.
// Decodes registered sync, active and pixel-coordinate outputs for the VGA port and pixel pipeline.
// Arbitrates one game-logic update window per frame, granted only during vertical blanking, so frame state never changes mid-scan.
// PARAMETERS
// CLK_DIV   4    sys clocks per pixel (100 MHz -> 25 MHz); >=2
// H_ACTIVE  640  visible pixels per line
// H_FP      16   horizontal front porch
// H_SYNC    96   hsync pulse width
// H_BP      48   horizontal back porch (H_TOTAL = 800)
// V_ACTIVE  480  visible lines
// V_FP      10   vertical front porch
// V_SYNC    2    vsync pulse width
// V_BP      33   vertical back porch (V_TOTAL = 525)
// PORTS
// clk        in   1   system clock; all logic on rising edge
// rst_n      in   1   asynchronous active-low reset
// enable     in   1   0: counters/divider held at 0, outputs at reset values
// pix_tick   out  1   1-clk pulse every CLK_DIV clks; pixel-advance strobe
// hsync      out  1   active-low horizontal sync
// vsync      out  1   active-low vertical sync
// active     out  1   1 while inside the visible 640x480 region
// pixel_x    out  10  current column, 0..799
// pixel_y    out  10  current line, 0..524
// line_end   out  1   1-clk pulse on the tick where h_cnt wraps 799->0
// frame_end  out  1   1-clk pulse on the tick where h=799 and v=524 wrap
// upd_req    in   1   game logic requests the update window (level)
// upd_done   in   1   game logic finished; 1-clk pulse while upd_gnt=1
// upd_gnt    out  1   update window granted (level)
// upd_abort  out  1   1-clk pulse: window closed by the controller before done
// BEHAVIOUR
// - Reset: div=h_cnt=v_cnt=0; hsync=vsync=1, active=0, pixel_x=pixel_y=0; all pulses 0; upd_gnt=0; FSM=IDLE.
// - Divider counts 0..CLK_DIV-1. pix_tick is registered and fires when div==CLK_DIV-1.
// - Counter advance: h_cnt increments on pix_tick and wraps 799->0. v_cnt increments on the h wrap and wraps 524->0.
// - Decode: active = h<640 && v<480. hsync=0 for h in 656..751 inclusive. vsync=0 for v in 490..491 inclusive.
// - Output alignment: hsync, vsync, active, pixel_x, pixel_y, line_end and frame_end are registered one stage after the counters.
//   These outputs are mutually aligned and change only on the clk after pix_tick.
// - enable=0: synchronous clear to reset values next clk, FSM to IDLE (upd_gnt drops, no abort pulse).
//   When enable returns to 1, the scan restarts at h=0, v=0.
// - Vblank window: v_cnt in 480..523. Line 524 is a guard line and is never inside the window.
// - FSM IDLE: upd_req=1 and inside window -> GRANT (upd_gnt=1 next clk).
//   upd_req=1 outside window -> WAIT.
// - FSM WAIT: move to GRANT on the clk after v_cnt reaches 480 (h=0). upd_req dropping returns the FSM to IDLE.
// - FSM GRANT: upd_done -> DONE; upd_gnt low next clk.
//   At the h=799 tick of line 523 without done -> DONE; upd_gnt low and upd_abort=1 for one clk.
//   upd_done and the close tick on the same clk count as done: no abort.
// - FSM DONE: no further grant this frame. Move to IDLE on frame_end.
// - upd_done outside GRANT is ignored. upd_req is ignored in DONE.
// - Async reset mid-frame or mid-grant: immediate return to reset values, no abort pulse.
// TESTING
// 1. Release reset, enable=1 -> pix_tick every 4 clks; line_end period 3200 clks; frame_end period 1,680,000 clks.
// 2. Sample at each pix_tick -> hsync low exactly for pixel_x 656..751; vsync low for pixel_y 490..491;
//    active count per frame = 307200.
// 3. upd_req raised at v=100 -> upd_gnt rises 1 clk after v reaches 480, h=0; upd_done at v=485 -> upd_gnt low next clk;
//    second req in same frame is not granted until the next frame.
// 4. upd_req held, no done -> upd_abort 1-clk pulse and upd_gnt falls at the h=799 tick of v=523;
//    upd_done on that same clk -> no abort.
// 5. enable=0 mid-line at h=300, v=200 -> all outputs at reset values next clk;
//    re-enable -> first active pixel at pixel_x=0, pixel_y=0.
// 6. rst_n asserted during GRANT -> upd_gnt=0, hsync=vsync=1 immediately without a clock edge; upd_abort stays 0.

Source files
------------

// File: rtl/vga_scan_controller.sv
// rtl/vga_scan_controller.sv - 640x480@60 scan sequencer with a vblank-only game update window
// Counters run on the pixel tick; decoded outputs are registered one clk behind the counters.
module vga_scan_controller #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_end,
   output logic       frame_end,
   input  logic       upd_req,
   input  logic       upd_done,
   output logic       upd_gnt,
   output logic       upd_abort
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_CLOSE = 10'(V_TOTAL - 2);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_GRANT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d, tick_dly_q;
   logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic             hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
   logic [9:0]       px_q, py_q;
   logic             line_end_q, line_end_d, frame_end_q, frame_end_d;
   logic [1:0]       state_q, state_d;
   logic             abort_q, abort_d;
   logic             h_last, in_window, close_tick, frame_wrap, open_ok;

   assign h_last     = (h_cnt_q == H_LAST);
   assign in_window  = (v_cnt_q >= V_VIS) && (v_cnt_q <= V_CLOSE);
   assign close_tick = tick_q && h_last && (v_cnt_q == V_CLOSE);
   assign frame_wrap = tick_q && h_last && (v_cnt_q == V_LAST);
   // A request seen on the closing tick must not open a window that would span the next frame.
   assign open_ok    = in_window && !close_tick;

   always_comb begin
      div_d   = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      tick_d  = (div_d == DIV_MAX);
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (tick_q) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
         if (h_last) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
      hsync_d     = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      vsync_d     = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      active_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      // Counters only sit at h=0 right after a tick when they have just wrapped.
      line_end_d  = tick_dly_q && (h_cnt_q == '0);
      frame_end_d = line_end_d && (v_cnt_q == '0);

      state_d = state_q;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE:  if (upd_req) state_d = open_ok ? S_GRANT : S_WAIT;
         S_WAIT: begin
            if (!upd_req)     state_d = S_IDLE;
            else if (open_ok) state_d = S_GRANT;
         end
         S_GRANT: begin
            if (upd_done) begin
               state_d = S_DONE;
            end else if (close_tick) begin
               state_d = S_DONE;
               abort_d = 1'b1;
            end
         end
         S_DONE:  if (frame_wrap) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;  tick_q <= 1'b0;  tick_dly_q <= 1'b0;
         h_cnt_q <= '0;  v_cnt_q <= '0;
         hsync_q <= 1'b1;  vsync_q <= 1'b1;  active_q <= 1'b0;
         px_q <= '0;  py_q <= '0;
         line_end_q <= 1'b0;  frame_end_q <= 1'b0;
         state_q <= S_IDLE;  abort_q <= 1'b0;
      end else if (!enable) begin
         div_q <= '0;  tick_q <= 1'b0;  tick_dly_q <= 1'b0;
         h_cnt_q <= '0;  v_cnt_q <= '0;
         hsync_q <= 1'b1;  vsync_q <= 1'b1;  active_q <= 1'b0;
         px_q <= '0;  py_q <= '0;
         line_end_q <= 1'b0;  frame_end_q <= 1'b0;
         state_q <= S_IDLE;  abort_q <= 1'b0;
      end else begin
         div_q <= div_d;  tick_q <= tick_d;  tick_dly_q <= tick_q;
         h_cnt_q <= h_cnt_d;  v_cnt_q <= v_cnt_d;
         hsync_q <= hsync_d;  vsync_q <= vsync_d;  active_q <= active_d;
         px_q <= h_cnt_q;  py_q <= v_cnt_q;
         line_end_q <= line_end_d;  frame_end_q <= frame_end_d;
         state_q <= state_d;  abort_q <= abort_d;
      end
   end

   assign pix_tick  = tick_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign active    = active_q;
   assign pixel_x   = px_q;
   assign pixel_y   = py_q;
   assign line_end  = line_end_q;
   assign frame_end = frame_end_q;
   assign upd_gnt   = (state_q == S_GRANT);
   assign upd_abort = abort_q;
endmodule
